axi_lite_sim_uart: RTL and testbench

AXI_LITE_SIM_UART -- requirements
Module: axi_lite_sim_uart

---
 rtl/sim_uart_pkg.sv | 50 +++++
 rtl/sim_uart_fifo.sv | 60 ++++++
 rtl/axi_lite_sim_uart.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_lite_sim_uart.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_uart_pkg.sv
// Shared definitions for the AXI-Lite simulation UART: register offsets
// (address bits [4:3]), AXI response codes, STATUS bit layout, the write
// FSM state type and the latched write command.
package sim_uart_pkg;

  localparam int unsigned REG_OFF_W = 2;

  localparam logic [REG_OFF_W-1:0] OFF_TXDATA = 2'd0;
  localparam logic [REG_OFF_W-1:0] OFF_STATUS = 2'd1;
  localparam logic [REG_OFF_W-1:0] OFF_CTRL   = 2'd2;
  localparam logic [REG_OFF_W-1:0] OFF_RSVD   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned STATUS_W         = 16;
  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  // Only the parts of a write that the register map can observe.
  typedef struct packed {
    logic [REG_OFF_W-1:0] off;
    logic                 strb0;
    logic [7:0]           data;
  } wr_cmd_t;

  // Pack the STATUS register; unlisted bits read as zero.
  function automatic logic [STATUS_W-1:0] status_word(input logic       empty,
                                                      input logic       full,
                                                      input logic       ovf,
                                                      input logic [7:0] count);
    logic [STATUS_W-1:0] s;
    s = '0;
    s[STATUS_EMPTY_BIT]        = empty;
    s[STATUS_FULL_BIT]         = full;
    s[STATUS_OVF_BIT]          = ovf;
    s[STATUS_COUNT_LSB +: 8]   = count;
    return s;
  endfunction

endpackage

// File: rtl/sim_uart_fifo.sv
// Byte FIFO for the simulation UART transmit path.
// Ports: clock/reset (sync, active-high); push/push_data write the tail;
// pop removes the head; head shows the oldest byte; full/empty/count
// reflect the state before the current cycle's push/pop.
module sim_uart_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         pop,
  output logic [7:0]                   head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so a same-cycle pop never
  // makes room for a push and a same-cycle push never feeds a pop.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      case ({do_push, do_pop})
        2'b10:   count <= CNT_W'(count + CNT_W'(1));
        2'b01:   count <= CNT_W'(count - CNT_W'(1));
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_sim_uart.sv
// AXI-Lite slave modelling a write-only UART: TXDATA writes fill a byte
// FIFO that drains one byte every DRAIN_DIV cycles onto the tx stream.
// Ports: clock/reset (sync, active-high); sys_aw/w/b write channels;
// sys_ar/r read channels; tx_valid/tx_ready/tx_byte drained characters.
// Optional macro SIM_UART_PRINT_EN: echo each drained byte to the console.
module axi_lite_sim_uart
  import sim_uart_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DRAIN_DIV  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sys_aw_valid,
  output logic              sys_aw_ready,
  input  logic [AW-1:0]     sys_aw_addr,
  input  logic              sys_w_valid,
  output logic              sys_w_ready,
  input  logic [DW-1:0]     sys_w_data,
  input  logic [DW/8-1:0]   sys_w_strb,
  output logic              sys_b_valid,
  input  logic              sys_b_ready,
  output logic [1:0]        sys_b_resp,
  input  logic              sys_ar_valid,
  output logic              sys_ar_ready,
  input  logic [AW-1:0]     sys_ar_addr,
  output logic              sys_r_valid,
  input  logic              sys_r_ready,
  output logic [DW-1:0]     sys_r_data,
  output logic [1:0]        sys_r_resp,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_byte
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DRAIN_DIV - 1);

  wr_state_t            wr_state;
  wr_state_t            wr_next;
  logic                 aw_hs, w_hs, b_hs, ar_hs;
  logic                 aw_ready_d, w_ready_d, b_valid_d, wr_exec;
  logic [REG_OFF_W-1:0] aw_off_q;
  logic [7:0]           w_byte_q;
  logic                 w_strb0_q;
  wr_cmd_t              cmd_c;
  logic [1:0]           wr_resp_d;
  logic                 fifo_push, ovf_set, ovf_clr, overflow;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]     fifo_count;
  logic [7:0]           fifo_head;

  logic                 r_valid_d;
  logic [DW-1:0]        rd_data_d;
  logic [1:0]           rd_resp_d;

  logic [DIV_W-1:0]     div_cnt;
  logic                 at_slot;
  logic                 unused_bits;

  assign aw_hs = sys_aw_valid & sys_aw_ready;
  assign w_hs  = sys_w_valid & sys_w_ready;
  assign b_hs  = sys_b_valid & sys_b_ready;
  assign ar_hs = sys_ar_valid & sys_ar_ready;

  // Address bits outside [4:3] and data/strobe lanes above byte 0 are ignored.
  assign unused_bits = ^{sys_aw_addr, sys_ar_addr, sys_w_data, sys_w_strb};

  // Write FSM: state register.
  always_ff @(posedge clock) begin
    if (reset) wr_state <= WR_IDLE;
    else       wr_state <= wr_next;
  end

  // Write FSM: next state.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_next = WR_RESP;
        else if (aw_hs)    wr_next = WR_HAVE_AW;
        else if (w_hs)     wr_next = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_hs)  wr_next = WR_RESP;
      WR_HAVE_W:  if (aw_hs) wr_next = WR_RESP;
      WR_RESP:    if (b_hs)  wr_next = WR_IDLE;
      default:    wr_next = WR_IDLE;
    endcase
  end

  // Write FSM: outputs for the coming cycle, registered below.
  always_comb begin
    aw_ready_d = (wr_next == WR_IDLE) || (wr_next == WR_HAVE_W);
    w_ready_d  = (wr_next == WR_IDLE) || (wr_next == WR_HAVE_AW);
    b_valid_d  = (wr_next == WR_RESP);
    wr_exec    = (wr_state != WR_RESP) && (wr_next == WR_RESP);
  end

  // Register decode for the write that completes this cycle; a channel
  // arriving now is used directly, the earlier one comes from its latch.
  always_comb begin
    cmd_c.off   = aw_hs ? sys_aw_addr[4:3] : aw_off_q;
    cmd_c.strb0 = w_hs  ? sys_w_strb[0]    : w_strb0_q;
    cmd_c.data  = w_hs  ? sys_w_data[7:0]  : w_byte_q;
    wr_resp_d   = RESP_OKAY;
    fifo_push   = 1'b0;
    ovf_set     = 1'b0;
    ovf_clr     = 1'b0;
    if (wr_exec) begin
      case (cmd_c.off)
        OFF_TXDATA: begin
          if (cmd_c.strb0) begin
            if (fifo_full) begin
              wr_resp_d = RESP_SLVERR;
              ovf_set   = 1'b1;
            end else begin
              fifo_push = 1'b1;
            end
          end
        end
        OFF_CTRL: ovf_clr   = cmd_c.strb0 & cmd_c.data[0];
        OFF_RSVD: wr_resp_d = RESP_SLVERR;
        default:  wr_resp_d = RESP_OKAY;
      endcase
    end
  end

  // Write channel registers and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      sys_aw_ready <= 1'b0;
      sys_w_ready  <= 1'b0;
      sys_b_valid  <= 1'b0;
      sys_b_resp   <= RESP_OKAY;
      aw_off_q     <= '0;
      w_byte_q     <= '0;
      w_strb0_q    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      sys_aw_ready <= aw_ready_d;
      sys_w_ready  <= w_ready_d;
      sys_b_valid  <= b_valid_d;
      if (wr_exec) sys_b_resp <= wr_resp_d;
      if (aw_hs)   aw_off_q   <= sys_aw_addr[4:3];
      if (w_hs) begin
        w_byte_q  <= sys_w_data[7:0];
        w_strb0_q <= sys_w_strb[0];
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Read path: response captured at the AR handshake.
  always_comb begin
    r_valid_d = sys_r_valid;
    if (ar_hs)                           r_valid_d = 1'b1;
    else if (sys_r_valid && sys_r_ready) r_valid_d = 1'b0;
    rd_data_d = '0;
    rd_resp_d = RESP_OKAY;
    case (sys_ar_addr[4:3])
      OFF_STATUS: rd_data_d = DW'(status_word(fifo_empty, fifo_full, overflow,
                                              8'(fifo_count)));
      OFF_RSVD:   rd_resp_d = RESP_SLVERR;
      default:    rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sys_ar_ready <= 1'b0;
      sys_r_valid  <= 1'b0;
      sys_r_data   <= '0;
      sys_r_resp   <= RESP_OKAY;
    end else begin
      sys_ar_ready <= ~r_valid_d;
      sys_r_valid  <= r_valid_d;
      if (ar_hs) begin
        sys_r_data <= rd_data_d;
        sys_r_resp <= rd_resp_d;
      end
    end
  end

  sim_uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (cmd_c.data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Drain: one slot per DRAIN_DIV cycles; a stalled sink parks the divider
  // on the slot so the byte goes out as soon as tx_ready returns.
  assign at_slot  = (div_cnt == DIV_LAST);
  assign fifo_pop = at_slot & tx_ready & ~fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt  <= '0;
      tx_valid <= 1'b0;
      tx_byte  <= '0;
    end else begin
      tx_valid <= fifo_pop;
      if (fifo_pop) tx_byte <= fifo_head;
      if (!at_slot)      div_cnt <= DIV_W'(div_cnt + DIV_W'(1));
      else if (tx_ready) div_cnt <= '0;
    end
  end

`ifdef SIM_UART_PRINT_EN
  // Console echo of the drained stream.
  always_ff @(posedge clock) begin
    if (!reset && tx_valid) $write("%c", tx_byte);
  end
`else
  // Console echo compiled out; port behaviour unchanged.
`endif

endmodule

// File: tb/tb_axi_lite_sim_uart.sv
module tb_axi_lite_sim_uart;

  localparam int DRAIN_DIV = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clock, reset;
  logic        sys_aw_valid, sys_aw_ready;
  logic [31:0] sys_aw_addr;
  logic        sys_w_valid, sys_w_ready;
  logic [63:0] sys_w_data;
  logic [7:0]  sys_w_strb;
  logic        sys_b_valid, sys_b_ready;
  logic [1:0]  sys_b_resp;
  logic        sys_ar_valid, sys_ar_ready;
  logic [31:0] sys_ar_addr;
  logic        sys_r_valid, sys_r_ready;
  logic [63:0] sys_r_data;
  logic [1:0]  sys_r_resp;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_byte;

  axi_lite_sim_uart #(
    .AW(32), .DW(64), .FIFO_DEPTH(16), .DRAIN_DIV(DRAIN_DIV)
  ) dut (
    .clock(clock), .reset(reset),
    .sys_aw_valid(sys_aw_valid), .sys_aw_ready(sys_aw_ready), .sys_aw_addr(sys_aw_addr),
    .sys_w_valid(sys_w_valid), .sys_w_ready(sys_w_ready), .sys_w_data(sys_w_data),
    .sys_w_strb(sys_w_strb),
    .sys_b_valid(sys_b_valid), .sys_b_ready(sys_b_ready), .sys_b_resp(sys_b_resp),
    .sys_ar_valid(sys_ar_valid), .sys_ar_ready(sys_ar_ready), .sys_ar_addr(sys_ar_addr),
    .sys_r_valid(sys_r_valid), .sys_r_ready(sys_r_ready), .sys_r_data(sys_r_data),
    .sys_r_resp(sys_r_resp),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
    logic [63:0] exp_rdata;
    bit          exp_tx;
  } vec_t;

  logic [1:0] b_exp_q[$];
  r_exp_t     r_exp_q[$];
  logic [7:0] tx_exp_q[$];
  vec_t       vecs[$];

  int          tx_seen = 0;
  int          b_seen = 0;
  bit          gap_check = 0;
  bit          have_last = 0;
  int unsigned last_tx_cycle = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Scoreboard: compare every B, R and tx beat against the queued expectation.
  always @(negedge clock) begin
    if (sys_b_valid && sys_b_ready) begin
      b_seen++;
      if (b_exp_q.size() == 0) fail_now("b_unexpected", 64'(sys_b_resp));
      else check("b_resp", 64'(sys_b_resp), 64'(b_exp_q.pop_front()));
    end
    if (sys_r_valid && sys_r_ready) begin
      r_exp_t e;
      if (r_exp_q.size() == 0) fail_now("r_unexpected", sys_r_data);
      else begin
        e = r_exp_q.pop_front();
        check("r_resp", 64'(sys_r_resp), 64'(e.resp));
        check("r_data", sys_r_data, e.data);
      end
    end
    if (tx_valid) begin
      tx_seen++;
      if (tx_exp_q.size() == 0) fail_now("tx_unexpected", 64'(tx_byte));
      else check("tx_byte", 64'(tx_byte), 64'(tx_exp_q.pop_front()));
      if (gap_check && have_last) check("tx_gap", 64'(cycle - last_tx_cycle), 64'(DRAIN_DIV));
      last_tx_cycle = cycle;
      have_last = 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input logic [1:0] exp_resp,
                          input bit expect_tx);
    bit aw_done, w_done, aw_now, w_now;
    int n;
    b_exp_q.push_back(exp_resp);
    if (expect_tx) tx_exp_q.push_back(data[7:0]);
    sys_aw_valid = 1'b1; sys_aw_addr = addr;
    sys_w_valid = 1'b1; sys_w_data = data; sys_w_strb = strb;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_now = sys_aw_valid && sys_aw_ready;
      w_now  = sys_w_valid && sys_w_ready;
      tick();
      n++;
      if (aw_now) begin aw_done = 1; sys_aw_valid = 1'b0; end
      if (w_now)  begin w_done = 1;  sys_w_valid = 1'b0;  end
    end
    if (!(aw_done && w_done)) begin
      fail_now("write_handshake_timeout", 64'(addr));
      sys_aw_valid = 1'b0; sys_w_valid = 1'b0;
      return;
    end
    check("b_latency", 64'(sys_b_valid), 64'd1);
    n = 0;
    while (b_exp_q.size() != 0 && n < 50) begin tick(); n++; end
    check("b_arrived", 64'(b_exp_q.size()), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [63:0] exp_data,
                         input logic [1:0] exp_resp);
    bit now, done;
    int n;
    r_exp_q.push_back({exp_data, exp_resp});
    sys_ar_valid = 1'b1; sys_ar_addr = addr;
    done = 0; n = 0;
    while (!done && n < 50) begin
      now = sys_ar_valid && sys_ar_ready;
      tick();
      n++;
      if (now) begin done = 1; sys_ar_valid = 1'b0; end
    end
    if (!done) begin
      fail_now("read_handshake_timeout", 64'(addr));
      sys_ar_valid = 1'b0;
      return;
    end
    check("r_latency", 64'(sys_r_valid), 64'd1);
    n = 0;
    while (r_exp_q.size() != 0 && n < 50) begin tick(); n++; end
    check("r_arrived", 64'(r_exp_q.size()), 64'd0);
  endtask

  task automatic wait_tx_drain(input int budget, input string name);
    int n;
    n = 0;
    while (tx_exp_q.size() != 0 && n < budget) begin tick(); n++; end
    check(name, 64'(tx_exp_q.size()), 64'd0);
  endtask

  function automatic vec_t mk_wr(input logic [31:0] a, input logic [63:0] d,
                                 input logic [7:0] s, input logic [1:0] r, input bit tx);
    vec_t v;
    v.is_read = 0; v.addr = a; v.data = d; v.strb = s;
    v.exp_resp = r; v.exp_rdata = '0; v.exp_tx = tx;
    return v;
  endfunction

  function automatic vec_t mk_rd(input logic [31:0] a, input logic [63:0] d, input logic [1:0] r);
    vec_t v;
    v.is_read = 1; v.addr = a; v.data = '0; v.strb = '0;
    v.exp_resp = r; v.exp_rdata = d; v.exp_tx = 0;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int tx_base, b_base;
    bit hs;

    // Register-map vectors run with the sink stalled so the FIFO fills.
    vecs.push_back(mk_rd(32'h08, 64'h0001, OKAY));
    vecs.push_back(mk_rd(32'h00, 64'h0, OKAY));
    vecs.push_back(mk_rd(32'h10, 64'h0, OKAY));
    vecs.push_back(mk_rd(32'h18, 64'h0, SLVERR));
    vecs.push_back(mk_wr(32'h18, 64'h77, 8'h01, SLVERR, 0));
    vecs.push_back(mk_rd(32'h08, 64'h0001, OKAY));
    vecs.push_back(mk_wr(32'h00, 64'h60, 8'hFE, OKAY, 0));
    vecs.push_back(mk_rd(32'h08, 64'h0001, OKAY));
    for (int i = 0; i < 17; i++) begin
      logic [31:0] a;
      logic [63:0] d;
      a = (i == 0) ? 32'h20 : 32'h00;
      d = (i == 1) ? 64'hDEAD_BEEF_0000_0051 : 64'(8'h50 + i);
      vecs.push_back(mk_wr(a, d, (i == 0) ? 8'hFF : 8'h01,
                           (i < 16) ? OKAY : SLVERR, i < 16));
    end
    vecs.push_back(mk_rd(32'h08, 64'h1006, OKAY));
    vecs.push_back(mk_rd(32'h108, 64'h1006, OKAY));
    vecs.push_back(mk_rd(32'h00, 64'h0, OKAY));
    vecs.push_back(mk_wr(32'h10, 64'h0, 8'h01, OKAY, 0));
    vecs.push_back(mk_rd(32'h08, 64'h1006, OKAY));
    vecs.push_back(mk_wr(32'h10, 64'h1, 8'h00, OKAY, 0));
    vecs.push_back(mk_rd(32'h08, 64'h1006, OKAY));
    vecs.push_back(mk_wr(32'h10, 64'h1, 8'h01, OKAY, 0));
    vecs.push_back(mk_rd(32'h08, 64'h1002, OKAY));

    reset = 1'b1;
    sys_aw_valid = 0; sys_aw_addr = '0;
    sys_w_valid = 0; sys_w_data = '0; sys_w_strb = '0;
    sys_b_ready = 1; sys_ar_valid = 0; sys_ar_addr = '0; sys_r_ready = 1;
    tx_ready = 0;

    repeat (3) tick();
    check("rst_aw_ready", 64'(sys_aw_ready), 64'd0);
    check("rst_w_ready", 64'(sys_w_ready), 64'd0);
    check("rst_ar_ready", 64'(sys_ar_ready), 64'd0);
    check("rst_b_valid", 64'(sys_b_valid), 64'd0);
    check("rst_r_valid", 64'(sys_r_valid), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_aw_ready", 64'(sys_aw_ready), 64'd1);
    check("post_rst_w_ready", 64'(sys_w_ready), 64'd1);
    check("post_rst_ar_ready", 64'(sys_ar_ready), 64'd1);

    // AW and W in the same cycle, byte drains at the next slot.
    tx_ready = 1;
    do_write(32'h0, 64'h41, 8'h01, OKAY, 1);
    wait_tx_drain(2 * DRAIN_DIV + 4, "drain_0x41");

    // W three cycles ahead of AW, B held off while new AW/W are offered.
    sys_b_ready = 0;
    b_exp_q.push_back(OKAY);
    tx_exp_q.push_back(8'h42);
    sys_w_valid = 1; sys_w_data = 64'h42; sys_w_strb = 8'h01;
    tick();
    sys_w_valid = 0;
    check("have_w_w_ready", 64'(sys_w_ready), 64'd0);
    check("have_w_aw_ready", 64'(sys_aw_ready), 64'd1);
    tick();
    tick();
    sys_aw_valid = 1; sys_aw_addr = 32'h0;
    hs = 0; n = 0;
    while (!hs && n < 20) begin
      hs = sys_aw_valid && sys_aw_ready;
      tick();
      n++;
    end
    check("late_aw_handshake", 64'(hs), 64'd1);
    check("late_aw_b_valid", 64'(sys_b_valid), 64'd1);
    sys_w_valid = 1; sys_w_data = 64'h99; sys_w_strb = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("resp_aw_ready", 64'(sys_aw_ready), 64'd0);
      check("resp_w_ready", 64'(sys_w_ready), 64'd0);
      check("resp_b_hold", 64'(sys_b_valid), 64'd1);
    end
    sys_aw_valid = 0; sys_w_valid = 0;
    sys_b_ready = 1;
    tick();
    check("b_done", 64'(sys_b_valid), 64'd0);
    check("b_single", 64'(b_exp_q.size()), 64'd0);
    wait_tx_drain(2 * DRAIN_DIV + 4, "drain_0x42");
    tx_ready = 0;
    repeat (2) tick();

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_read) do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp);
      else do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, vecs[i].exp_tx);
    end

    // Release the sink: sixteen bytes in order, evenly spaced.
    have_last = 0;
    gap_check = 1;
    tx_ready = 1;
    wait_tx_drain(16 * DRAIN_DIV + 20, "drain_full");
    gap_check = 0;
    repeat (2) tick();
    do_read(32'h08, 64'h0001, OKAY);

    // Reset with a pending B and queued bytes: nothing may leak out.
    tx_ready = 0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) do_write(32'h0, 64'(8'h70 + i), 8'h01, OKAY, 0);
    sys_b_ready = 0;
    sys_aw_valid = 1; sys_aw_addr = 32'h0;
    sys_w_valid = 1; sys_w_data = 64'h75; sys_w_strb = 8'h01;
    hs = 0; n = 0;
    while (!hs && n < 20) begin
      hs = sys_aw_valid && sys_aw_ready && sys_w_valid && sys_w_ready;
      tick();
      n++;
    end
    sys_aw_valid = 0; sys_w_valid = 0;
    check("pending_b_valid", 64'(sys_b_valid), 64'd1);
    reset = 1;
    tick();
    check("mid_rst_b_valid", 64'(sys_b_valid), 64'd0);
    check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    tick();
    reset = 0;
    tx_base = tx_seen;
    b_base = b_seen;
    sys_b_ready = 1;
    tx_ready = 1;
    repeat (10 * DRAIN_DIV) tick();
    check("no_tx_after_rst", 64'(tx_seen - tx_base), 64'd0);
    check("no_b_after_rst", 64'(b_seen - b_base), 64'd0);
    do_read(32'h08, 64'h0001, OKAY);

    check("b_queue_empty", 64'(b_exp_q.size()), 64'd0);
    check("r_queue_empty", 64'(r_exp_q.size()), 64'd0);
    check("tx_queue_empty", 64'(tx_exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
